// File: rtl/i2c_write_sequencer_pkg.sv
// i2c_pkg: shared constants, FSM states and command packing for the I2C write sequencer.
package i2c_pkg;
    localparam logic not_busy = 1'b1;
    localparam logic busy = 1'b0;
    localparam int cmd_w = 24;
    typedef logic [cmd_w-1:0] cmd_t;
    typedef enum logic [2:0] {
        st_idle,
        st_load,
        st_issue,
        st_wait_busy,
        st_wait_done
    } state_t;
    function automatic cmd_t pack_cmd(input logic [7:0] address, input logic [7:0] register, input logic [7:0] data);
        return {address, register, data};
    endfunction
endpackage

// File: rtl/i2c_write_sequencer_if.sv
// i2c_write_sequencer_if: user command port plus the link to i2c_master_write_byte.
interface i2c_write_sequencer_if #(parameter int FIFO_DEPTH = 4);
    localparam int cw = $clog2(FIFO_DEPTH) + 1;
    logic cmd_push;
    logic [7:0] cmd_address;
    logic [7:0] cmd_register;
    logic [7:0] cmd_data;
    logic cmd_full;
    logic [cw-1:0] cmd_count;
    logic [7:0] slave_address;
    logic [7:0] slave_register;
    logic [7:0] slave_data;
    logic enable_send;
    logic i2c_busy;
    logic [7:0] i2c_status;
    logic status_valid;
    logic [7:0] last_status;
    logic timeout_err;
    logic idle;
    modport slave (
        input cmd_push, cmd_address, cmd_register, cmd_data, i2c_busy, i2c_status,
        output cmd_full, cmd_count, slave_address, slave_register, slave_data,
        output enable_send, status_valid, last_status, timeout_err, idle
    );
    modport master (
        output cmd_push, cmd_address, cmd_register, cmd_data, i2c_busy, i2c_status,
        input cmd_full, cmd_count, slave_address, slave_register, slave_data,
        input enable_send, status_valid, last_status, timeout_err, idle
    );
endinterface

// File: rtl/i2c_write_sequencer_cmd_fifo.sv
// i2c_cmd_fifo: synchronous command FIFO; pointers carry an extra wrap bit so count reaches DEPTH.
module i2c_cmd_fifo
    import i2c_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  cmd_t wdata,
    output cmd_t rdata,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int aw = $clog2(DEPTH);
    cmd_t mem [DEPTH];
    logic [aw:0] wp, rp;
    logic wr;
    assign count = wp - rp;
    assign full = count[aw];
    assign empty = wp == rp;
    // A pop frees the head slot in the same edge, so a full FIFO may still accept
    assign wr = push && (!full || pop);
    assign rdata = mem[rp[aw-1:0]];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (wr) mem[wp[aw-1:0]] <= wdata;
    end
endmodule

// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer: queues write commands and issues them to the I2C master via a toggle handshake.
module i2c_write_sequencer
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BUSY_TIMEOUT = 1024
) (
    input logic clock,
    input logic reset,
    i2c_write_sequencer_if.slave bus
);
    localparam int tw = $clog2(BUSY_TIMEOUT + 1);
    state_t state, state_nx;
    logic busy_s1, busy_s2;
    logic [7:0] status_s1, status_s2;
    logic [tw-1:0] cnt;
    cmd_t head;
    logic empty, pop, expired;
    i2c_cmd_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
        .clock(clock),
        .reset(reset),
        .push(bus.cmd_push),
        .pop(pop),
        .wdata(pack_cmd(bus.cmd_address, bus.cmd_register, bus.cmd_data)),
        .rdata(head),
        .full(bus.cmd_full),
        .empty(empty),
        .count(bus.cmd_count)
    );
    assign expired = cnt == tw'(BUSY_TIMEOUT - 1);
    // The head is only released once the transfer finishes or times out
    assign pop = (state == st_wait_done && busy_s2 == not_busy) ||
                 (state == st_wait_busy && busy_s2 != busy && expired);
    assign bus.idle = empty && state == st_idle;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_s1 <= not_busy;
            busy_s2 <= not_busy;
            status_s1 <= '0;
            status_s2 <= '0;
            state <= st_idle;
        end else begin
            busy_s1 <= bus.i2c_busy;
            busy_s2 <= busy_s1;
            status_s1 <= bus.i2c_status;
            status_s2 <= status_s1;
            state <= state_nx;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            st_idle: state_nx = (!empty && busy_s2 == not_busy) ? st_load : st_idle;
            st_load: state_nx = st_issue;
            st_issue: state_nx = st_wait_busy;
            st_wait_busy: state_nx = (busy_s2 == busy) ? st_wait_done : (expired ? st_idle : st_wait_busy);
            st_wait_done: state_nx = (busy_s2 == not_busy) ? st_idle : st_wait_done;
            default: state_nx = st_idle;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.slave_address <= '0;
            bus.slave_register <= '0;
            bus.slave_data <= '0;
            bus.enable_send <= 1'b0;
            bus.status_valid <= 1'b0;
            bus.last_status <= '0;
            bus.timeout_err <= 1'b0;
            cnt <= '0;
        end else begin
            bus.status_valid <= 1'b0;
            if (state == st_load) {bus.slave_address, bus.slave_register, bus.slave_data} <= head;
            if (state == st_issue) begin
                bus.enable_send <= ~bus.enable_send;
                cnt <= '0;
            end
            if (state == st_wait_busy && busy_s2 != busy) begin
                cnt <= cnt + 1'b1;
                if (expired) bus.timeout_err <= 1'b1;
            end
            if (state == st_wait_done && busy_s2 == not_busy) begin
                bus.last_status <= status_s2;
                bus.status_valid <= 1'b1;
            end
        end
    end
endmodule
